change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vending_pkg.sv | 45 ++++
 rtl/coin_tube.sv | 29 ++
 rtl/change_dispenser.sv | 113 +++++++++++
 tb/tb_change_dispenser.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared vending definitions: change codes, coin values and the
// dispenser state encoding, plus helpers to decode a change code.
package vending_pkg;

  // Change code presented by the vending controller alongside soda.
  typedef enum logic [2:0] {
    CHG_NONE = 3'b000,
    CHG_5    = 3'b001,
    CHG_10   = 3'b010,
    CHG_15   = 3'b011,
    CHG_20   = 3'b100
  } chg_code_e;

  // Coin values and item price in cents (5-bit range covers all of them).
  localparam logic [4:0] NICKLE_VAL  = 5'd5;
  localparam logic [4:0] DIME_VAL    = 5'd10;
  localparam logic [4:0] QUARTER_VAL = 5'd25;
  localparam logic [4:0] PRICE_VAL   = 5'd20;

  // Dispenser control states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } disp_state_e;

  // Codes above CHG_20 carry no meaning and are rejected.
  function automatic logic chg_valid(input logic [2:0] code);
    return (code <= 3'd4);
  endfunction

  // Amount of change owed for a code; zero for none/invalid codes.
  function automatic logic [4:0] chg_value(input logic [2:0] code);
    logic [4:0] val;
    case (code)
      CHG_5:   val = 5'd5;
      CHG_10:  val = 5'd10;
      CHG_15:  val = 5'd15;
      CHG_20:  val = 5'd20;
      default: val = 5'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_tube.sv
// One coin tube: a saturating 4-bit down counter with refill to capacity.
// Refill wins over a same-edge decrement; the count never wraps below 0.
module coin_tube #(
  parameter logic [3:0] CAP = 4'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec,
  input  logic       refill,
  output logic [3:0] count,
  output logic       empty
);

  // Tube contents: reset/refill load capacity, dec removes one coin if any.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CAP;
    end else if (refill) begin
      count <= CAP;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end else begin
      count <= count;
    end
  end

  assign empty = (count == 4'd0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out change greedily (dimes first, then nickels),
// one coin per cycle, reporting done when paid or short when it cannot pay.
module change_dispenser
  import vending_pkg::*;
#(
  parameter logic [3:0] NICKLE_CAP = 4'd8,
  parameter logic [3:0] DIME_CAP   = 4'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soda,
  input  logic [2:0] change,
  input  logic       refill,
  output logic       nickle_out,
  output logic       dime_out,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [3:0] nickle_cnt,
  output logic [3:0] dime_cnt
);

  disp_state_e state;
  logic [4:0]  remaining;
  logic        nickle_empty;
  logic        dime_empty;
  logic        use_dime;
  logic        use_nickle;

  // Coin selection for this edge: a dime when it fits and one is left,
  // otherwise a nickel under the same conditions.
  assign use_dime   = (state == ST_DISPENSE) && (remaining >= DIME_VAL) && !dime_empty;
  assign use_nickle = (state == ST_DISPENSE) && !use_dime &&
                      (remaining >= NICKLE_VAL) && !nickle_empty;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  coin_tube #(.CAP(NICKLE_CAP)) u_nickle_tube (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec    (use_nickle),
    .refill (refill),
    .count  (nickle_cnt),
    .empty  (nickle_empty)
  );

  coin_tube #(.CAP(DIME_CAP)) u_dime_tube (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec    (use_dime),
    .refill (refill),
    .count  (dime_cnt),
    .empty  (dime_empty)
  );

  // Control FSM with registered coin and short pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= 5'd0;
      nickle_out <= 1'b0;
      dime_out   <= 1'b0;
      short      <= 1'b0;
    end else begin
      nickle_out <= 1'b0;
      dime_out   <= 1'b0;
      short      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (soda) begin
            if (change == CHG_NONE) begin
              state <= ST_DONE;
            end else if (chg_valid(change)) begin
              remaining <= chg_value(change);
              state     <= ST_DISPENSE;
            end else begin
              short <= 1'b1;
            end
          end
        end
        ST_DISPENSE: begin
          if (use_dime) begin
            dime_out  <= 1'b1;
            remaining <= remaining - DIME_VAL;
            if (remaining == DIME_VAL) begin
              state <= ST_DONE;
            end
          end else if (use_nickle) begin
            nickle_out <= 1'b1;
            remaining  <= remaining - NICKLE_VAL;
            if (remaining == NICKLE_VAL) begin
              state <= ST_DONE;
            end
          end else begin
            // Nothing usable left: give up; coins already paid stay paid.
            short     <= 1'b1;
            remaining <= 5'd0;
            state     <= ST_IDLE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          remaining <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// transactions, compared cycle by cycle against a greedy payout model.
module tb_change_dispenser;

  localparam logic [3:0] NC = 4'd8;
  localparam logic [3:0] DC = 4'd8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       soda = 1'b0;
  logic [2:0] change = 3'd0;
  logic       refill = 1'b0;
  logic       nickle_out, dime_out, busy, done, short;
  logic [3:0] nickle_cnt, dime_cnt;

  change_dispenser #(.NICKLE_CAP(NC), .DIME_CAP(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soda       (soda),
    .change     (change),
    .refill     (refill),
    .nickle_out (nickle_out),
    .dime_out   (dime_out),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .nickle_cnt (nickle_cnt),
    .dime_cnt   (dime_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs after one clock edge.
  typedef struct {
    bit n, d, dn, sh, bz, rf;
    int nc, dc;
  } exp_t;

  exp_t q[$];
  int   mn, md;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Build the per-edge expectation list for one request (edge 0 samples soda).
  // Payout rule: each cycle take a dime if 10+ is owed and a dime is left,
  // else a nickel if 5+ is owed and a nickel is left, else report short.
  function automatic void model_txn(input int code, input int rf_edge);
    exp_t e;
    int   rem;
    int   j;
    q.delete();
    e = '{default: 0};
    e.nc = mn; e.dc = md;
    if (code > 4) begin
      e.sh = 1'b1;
      q.push_back(e);
    end else if (code == 0) begin
      e.dn = 1'b1; e.bz = 1'b1;
      q.push_back(e);
    end else begin
      e.bz = 1'b1;
      q.push_back(e);
      rem = 5 * code;
      j = 1;
      while (1) begin
        e = '{default: 0};
        if (rem >= 10 && md > 0) begin
          e.d = 1'b1; md--; rem -= 10;
        end else if (rem >= 5 && mn > 0) begin
          e.n = 1'b1; mn--; rem -= 5;
        end else begin
          e.sh = 1'b1;
        end
        if (j == rf_edge) begin
          e.rf = 1'b1; mn = NC; md = DC;
        end
        e.dn = !e.sh && (rem == 0);
        e.bz = !e.sh;
        e.nc = mn; e.dc = md;
        q.push_back(e);
        if (e.sh || rem == 0) break;
        j++;
      end
    end
    e = '{default: 0};
    e.nc = mn; e.dc = md;
    q.push_back(e);
  endfunction

  task automatic check_entry(input string tag, input exp_t e);
    chk({tag, " nickle_out"}, {7'd0, nickle_out}, {7'd0, e.n});
    chk({tag, " dime_out"},   {7'd0, dime_out},   {7'd0, e.d});
    chk({tag, " done"},       {7'd0, done},       {7'd0, e.dn});
    chk({tag, " short"},      {7'd0, short},      {7'd0, e.sh});
    chk({tag, " busy"},       {7'd0, busy},       {7'd0, e.bz});
    chk({tag, " nickle_cnt"}, {4'd0, nickle_cnt}, 8'(e.nc));
    chk({tag, " dime_cnt"},   {4'd0, dime_cnt},   8'(e.dc));
  endtask

  // Issue one request starting at a falling edge; optionally assert refill
  // on a payout edge and hammer soda while the dispenser is busy.
  task automatic run(input int code, input int rf_edge, input bit noise);
    model_txn(code, rf_edge);
    foreach (q[i]) begin
      refill = q[i].rf;
      if (i == 0) begin
        soda = 1'b1; change = 3'(code);
      end else if (noise && q[i-1].bz) begin
        soda = 1'b1; change = 3'($urandom_range(0, 7));
      end else begin
        soda = 1'b0; change = 3'($urandom_range(0, 7));
      end
      @(posedge clk);
      @(negedge clk);
      check_entry($sformatf("code%0d edge%0d", code, i), q[i]);
    end
    soda = 1'b0;
    refill = 1'b0;
  endtask

  task automatic idle_refill();
    exp_t e;
    refill = 1'b1; soda = 1'b0;
    @(posedge clk);
    @(negedge clk);
    refill = 1'b0;
    mn = NC; md = DC;
    e = '{default: 0};
    e.nc = mn; e.dc = md;
    check_entry("idle_refill", e);
  endtask

  initial begin
    exp_t e;
    int   code, rf;
    bit   noise;

    // Power-on reset.
    #2 rst_n = 1'b0;
    #1;
    mn = NC; md = DC;
    e = '{default: 0};
    e.nc = mn; e.dc = md;
    check_entry("reset", e);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 15 cents from full tubes: dime, then nickel with done.
    run(3, -1, 1'b0);

    // Drain the dimes, then 20 cents must come as four nickels.
    idle_refill();
    repeat (4) run(4, -1, 1'b1);
    run(4, -1, 1'b0);

    // Reach nickels=0, dimes=1; 15 cents pays one dime then shorts.
    idle_refill();
    repeat (3) run(4, -1, 1'b0);
    run(3, -1, 1'b0);
    repeat (7) run(1, -1, 1'b0);
    run(3, -1, 1'b0);

    // Invalid code and no-change code.
    run(6, -1, 1'b0);
    run(0, -1, 1'b0);

    // Refill on the first dime edge of a 20-cent payout.
    idle_refill();
    run(4, 1, 1'b0);

    // Reset in the middle of a 20-cent payout.
    idle_refill();
    soda = 1'b1; change = 3'd4;
    @(posedge clk);
    @(negedge clk);
    change = 3'd1;
    @(posedge clk);
    @(negedge clk);
    soda = 1'b0;
    chk("midreset pre dime_out", {7'd0, dime_out}, 8'd1);
    chk("midreset pre dime_cnt", {4'd0, dime_cnt}, 8'(DC - 4'd1));
    #2 rst_n = 1'b0;
    #1;
    mn = NC; md = DC;
    e = '{default: 0};
    e.nc = mn; e.dc = md;
    check_entry("midreset async", e);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_entry("after midreset", e);
    end

    // Random requests.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) == 0) idle_refill();
      code  = $urandom_range(0, 7);
      rf    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : -1;
      noise = 1'($urandom_range(0, 1));
      run(code, rf, noise);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
